// File: rtl/posit_lut_loader_if.sv
// rtl/posit_lut_loader_if.sv - load stream and lookup bus of the runtime posit function table
interface posit_lut_loader_if #(
    parameter int WIDTH = 8
);
    logic             load_start;
    logic [WIDTH-1:0] load_data;
    logic             load_valid;
    logic             load_ready;
    logic             load_done;
    logic             table_valid;
    logic [15:0]      checksum;
    logic [WIDTH-1:0] lut_in;
    logic             lut_in_valid;
    logic [WIDTH-1:0] lut_out;
    logic             lut_out_valid;

    modport master (
        output load_start, load_data, load_valid, lut_in, lut_in_valid,
        input  load_ready, load_done, table_valid, checksum, lut_out, lut_out_valid
    );

    modport slave (
        input  load_start, load_data, load_valid, lut_in, lut_in_valid,
        output load_ready, load_done, table_valid, checksum, lut_out, lut_out_valid
    );
endinterface

// File: rtl/posit_lut_loader.sv
// rtl/posit_lut_loader.sv - streams a 2^WIDTH-entry posit function table into memory and serves lookups
module posit_lut_loader #(
    parameter int WIDTH = 8,
    parameter int ES    = 1
) (
    input  logic                i_clock,
    input  logic                i_reset,
    posit_lut_loader_if.slave   io_lut
);
    localparam int DEPTH = 1 << WIDTH;

    // ES only tags the table's number format; reject values no posit of this width can hold
    if (ES < 0 || ES > WIDTH - 3) begin : g_bad_es
        $error("posit_lut_loader: ES out of range for WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [WIDTH:0]    r_addr;
    logic [15:0]       r_checksum;
    logic              r_load_done;
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_lut_addr;
    logic              r_lut_q;
    logic [WIDTH-1:0]  r_lut_out;
    logic              r_lut_out_valid;

    logic              w_load_ready;
    logic              w_table_valid;
    logic              w_accept;
    logic              w_last_beat;

    assign w_accept    = io_lut.load_valid && w_load_ready;
    assign w_last_beat = (r_addr == (WIDTH+1)'(DEPTH - 1));

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // load_start restarts from any state, including an unfinished load
    always_comb begin
        w_next_state = r_state;
        if (io_lut.load_start) begin
            w_next_state = ST_LOAD;
        end else begin
            case (r_state)
                ST_IDLE: w_next_state = ST_IDLE;
                ST_LOAD: if (w_accept && w_last_beat) w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_DONE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_load_ready  = 1'b0;
        w_table_valid = 1'b0;
        case (r_state)
            ST_LOAD: w_load_ready  = !io_lut.load_start;
            ST_DONE: w_table_valid = 1'b1;
            default: begin
                w_load_ready  = 1'b0;
                w_table_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_addr      <= '0;
            r_checksum  <= '0;
            r_load_done <= 1'b0;
        end else begin
            r_load_done <= w_accept && w_last_beat;
            if (io_lut.load_start) begin
                r_addr     <= '0;
                r_checksum <= '0;
            end else if (w_accept) begin
                r_addr     <= r_addr + 1'b1;
                r_checksum <= r_checksum + 16'(io_lut.load_data);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (w_accept) begin
            r_mem[r_addr[WIDTH-1:0]] <= io_lut.load_data;
        end
    end

    // Two-stage lookup; a dropped request leaves the previous result on lut_out
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_lut_addr      <= '0;
            r_lut_q         <= 1'b0;
            r_lut_out       <= '0;
            r_lut_out_valid <= 1'b0;
        end else begin
            r_lut_addr      <= io_lut.lut_in;
            r_lut_q         <= io_lut.lut_in_valid && w_table_valid;
            r_lut_out_valid <= r_lut_q;
            if (r_lut_q) begin
                r_lut_out <= r_mem[r_lut_addr];
            end
        end
    end

    assign io_lut.load_ready    = w_load_ready;
    assign io_lut.load_done     = r_load_done;
    assign io_lut.table_valid   = w_table_valid;
    assign io_lut.checksum      = r_checksum;
    assign io_lut.lut_out       = r_lut_out;
    assign io_lut.lut_out_valid = r_lut_out_valid;
endmodule

// File: tb/tb_posit_lut_loader.sv
// tb/tb_posit_lut_loader.sv - directed bench for posit_lut_loader with a lookup scoreboard
module tb_posit_lut_loader;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    posit_lut_loader_if #(.WIDTH(W)) bus ();

    posit_lut_loader #(.WIDTH(W), .ES(1)) dut (
        .i_clock (clk),
        .i_reset (rst),
        .io_lut  (bus)
    );

    typedef struct {
        int         due;
        logic       v;
        logic [7:0] d;
    } exp_t;

    exp_t       sbq[$];
    exp_t       e;
    logic [7:0] model [256];
    logic       exp_tv;
    logic [7:0] exp_last;
    logic [15:0] exp_cs;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_pulses = 0;
    int run = 0;
    int max_run = 0;
    int pulses_before;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.load_done === 1'b1) done_pulses++;
        if (bus.lut_out_valid === 1'b1) run++;
        else run = 0;
        if (run > max_run) max_run = run;
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            chk("lut_out_valid", {31'd0, bus.lut_out_valid}, {31'd0, e.v});
            chk("lut_out", {24'd0, bus.lut_out}, {24'd0, e.d});
        end else begin
            chk("lut_out_valid_idle", {31'd0, bus.lut_out_valid}, 32'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lookup(input logic [7:0] a);
        bus.lut_in       = a;
        bus.lut_in_valid = 1'b1;
        if (exp_tv) exp_last = model[a];
        sbq.push_back('{cyc + 2, exp_tv, exp_last});
    endtask

    function automatic logic [7:0] pat(input int p, input int i);
        logic [7:0] b;
        b = 8'(i);
        return (p == 0) ? (b ^ 8'hFF) : b;
    endfunction

    // pattern p, randomly gapped if gap, stops after n accepted beats
    task automatic do_load(input int p, input bit gap, input int n);
        int i;
        int guard;
        tick();
        bus.lut_in_valid = 1'b0;
        bus.load_start   = 1'b1;
        bus.load_valid   = 1'b1;
        bus.load_data    = 8'hAA;
        @(negedge clk);
        chk("ready_during_start", {31'd0, bus.load_ready}, 32'd0);
        tick();
        bus.load_start = 1'b0;
        exp_tv = 1'b0;
        exp_cs = 16'd0;
        i = 0;
        guard = 0;
        while (i < n && guard < 4000) begin
            bus.load_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.load_data  = pat(p, i);
            @(negedge clk);
            chk("ready_in_load", {31'd0, bus.load_ready}, 32'd1);
            chk("table_valid_in_load", {31'd0, bus.table_valid}, 32'd0);
            if (bus.load_valid && bus.load_ready) begin
                model[i] = bus.load_data;
                exp_cs   = exp_cs + 16'(bus.load_data);
                i++;
            end
            guard++;
            if (i < n) tick();
        end
        chk("load_beats", i, n);
        if (!gap) chk("gapless_cycles", guard, n);
    endtask

    task automatic finish_load();
        tick();
        bus.load_valid = 1'b0;
        @(negedge clk);
        chk("load_done_pulse", {31'd0, bus.load_done}, 32'd1);
        chk("table_valid_at_done", {31'd0, bus.table_valid}, 32'd1);
        chk("checksum_at_done", {16'd0, bus.checksum}, {16'd0, exp_cs});
        exp_tv = 1'b1;
        tick();
        @(negedge clk);
        chk("load_done_single", {31'd0, bus.load_done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.load_start   = 1'b0;
        bus.load_data    = 8'h00;
        bus.load_valid   = 1'b0;
        bus.lut_in       = 8'h00;
        bus.lut_in_valid = 1'b0;
        exp_tv   = 1'b0;
        exp_last = 8'h00;
        exp_cs   = 16'd0;
        repeat (2) tick();
        chk("rst_load_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("rst_load_done", {31'd0, bus.load_done}, 32'd0);
        chk("rst_table_valid", {31'd0, bus.table_valid}, 32'd0);
        chk("rst_checksum", {16'd0, bus.checksum}, 32'd0);
        chk("rst_lut_out", {24'd0, bus.lut_out}, 32'd0);
        rst = 1'b0;

        // lookup before any load is dropped
        tick();
        bus.load_valid = 1'b1;
        lookup(8'h40);
        @(negedge clk);
        chk("idle_ready", {31'd0, bus.load_ready}, 32'd0);
        tick();
        bus.lut_in_valid = 1'b0;
        bus.load_valid   = 1'b0;
        repeat (3) tick();

        // gapless full load, inverted pattern
        pulses_before = done_pulses;
        do_load(0, 1'b0, 256);
        finish_load();
        chk("done_pulse_count", done_pulses - pulses_before, 1);
        tick();
        lookup(8'h40);
        tick();
        bus.lut_in_valid = 1'b0;
        repeat (3) tick();
        chk("lookup_40", {24'd0, exp_last}, 32'hBF);
        chk("checksum_hold", {16'd0, bus.checksum}, 32'h7F80);

        // gapped reload from DONE
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        tick();
        bus.load_start = 1'b1;
        @(negedge clk);
        chk("tv_still_high_on_start", {31'd0, bus.table_valid}, 32'd1);
        tick();
        bus.load_start = 1'b0;
        @(negedge clk);
        chk("tv_drops_after_start", {31'd0, bus.table_valid}, 32'd0);
        chk("checksum_cleared", {16'd0, bus.checksum}, 32'd0);
        do_load(0, 1'b1, 256);
        finish_load();
        chk("gapped_checksum", {16'd0, exp_cs}, 32'h7F80);

        // back-to-back lookups across the whole table
        max_run = 0;
        for (int a = 0; a < 256; a++) begin
            tick();
            lookup(8'(a));
        end
        tick();
        bus.lut_in_valid = 1'b0;
        repeat (4) tick();
        chk("b2b_run", max_run, 256);

        // abort at beat 100, then identity reload
        do_load(1, 1'b0, 100);
        do_load(1, 1'b0, 256);
        finish_load();
        chk("identity_checksum", {16'd0, bus.checksum}, 32'h7F80);
        tick();
        lookup(8'h05);
        tick();
        bus.lut_in_valid = 1'b0;
        repeat (4) tick();
        chk("lookup_05", {24'd0, exp_last}, 32'h05);
        chk("lut_out_nonzero_before_rst", {24'd0, bus.lut_out}, 32'h05);

        // asynchronous reset mid-load
        do_load(0, 1'b0, 10);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_load_ready", {31'd0, bus.load_ready}, 32'd0);
        chk("arst_load_done", {31'd0, bus.load_done}, 32'd0);
        chk("arst_table_valid", {31'd0, bus.table_valid}, 32'd0);
        chk("arst_checksum", {16'd0, bus.checksum}, 32'd0);
        chk("arst_lut_out", {24'd0, bus.lut_out}, 32'd0);
        chk("arst_lut_out_valid", {31'd0, bus.lut_out_valid}, 32'd0);
        exp_tv   = 1'b0;
        exp_last = 8'h00;
        repeat (2) tick();
        rst = 1'b0;
        bus.load_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, bus.load_ready}, 32'd0);
        tick();
        lookup(8'h05);
        @(negedge clk);
        chk("post_rst_ready_2", {31'd0, bus.load_ready}, 32'd0);
        tick();
        bus.lut_in_valid = 1'b0;
        bus.load_valid   = 1'b0;
        repeat (4) tick();
        chk("post_rst_table_valid", {31'd0, bus.table_valid}, 32'd0);
        chk("scoreboard_drained", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/posit_lut_loader.md
Name: posit_lut_loader

Overview:
- Runtime-writable posit function table: streams 2^WIDTH entries into on-chip table memory, then serves posit lookups from it.
- Write-side counterpart of the fixed, file-initialised posit LUT function blocks (inverse and similar).
- Lets a host or DMA engine reprogram any unary posit function (inv, sqrt, exp, ...) without resynthesis.

Parameters:
- WIDTH, 8, posit width in bits; table depth = 2^WIDTH, entry width = WIDTH.
- ES, 1, posit exponent size; metadata only, carried for consistency with other posit blocks; no effect on logic.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  single-cycle pulse: begin a full table load at address 0.
- load_data  in  WIDTH  table entry for the current load address.
- load_valid  in  1  load_data valid.
- load_ready  out  1  loader accepts a beat this cycle.
- load_done  out  1  one-cycle pulse when the final entry is written.
- table_valid  out  1  level: table fully loaded and usable.
- checksum  out  16  running sum of loaded entries, zero-extended, mod 2^16.
- lut_in  in  WIDTH  posit operand (table address).
- lut_in_valid  in  1  lookup request.
- lut_out  out  WIDTH  looked-up result.
- lut_out_valid  out  1  lut_out valid.

Behaviour:
- Reset (async, active-high):
  - state=IDLE; load_ready=0, load_done=0, table_valid=0, checksum=0, lut_out=0, lut_out_valid=0.
  - Address counter and lookup pipeline cleared.
  - Memory contents not reset.
- FSM states:
  - IDLE: load_ready=0; load_start -> LOAD.
  - LOAD: load_ready=1 unless load_start is high this cycle.
    - A beat is accepted when load_valid && load_ready.
    - On accept: mem[addr] <= load_data, checksum += load_data, addr += 1.
    - On accept at addr = 2^WIDTH-1 -> DONE.
  - DONE: table_valid=1; load_start -> LOAD.
- load_start in any state, including mid-load:
  - Next cycle: state=LOAD, addr=0, checksum=0, table_valid=0.
  - A beat presented in the same cycle as load_start is not accepted (load_ready=0 that cycle).
  - Entries already written by an aborted load stay in memory and are overwritten by the new load.
- load_done:
  - Asserted in the cycle after the final beat is accepted, i.e. the first cycle of DONE.
  - table_valid rises in that same cycle.
- load_valid with load_ready=0 is ignored; no beat is lost or buffered.
- Address counter is WIDTH+1 bits internally; no wrap: the final beat terminates LOAD.
- Lookup pipeline (fixed latency 2):
  - Cycle N: lut_in sampled along with qualifier q = lut_in_valid && table_valid.
  - Cycle N+1: registered memory read.
  - Cycle N+2: lut_out = mem[lut_in], lut_out_valid = q.
  - Fully pipelined: one lookup per cycle, no backpressure.
  - Requests with table_valid=0 at cycle N are dropped: lut_out_valid=0 at N+2, lut_out holds its previous value.
- Lookups in flight when load_start arrives complete with their qualifier as sampled.
  - Data read after the first new-load write may reflect new contents; software must quiesce lookups before reloading.
- Same-address read and write in one cycle: read returns the old value.
  - Only reachable via in-flight lookups during the first beats of a reload.
- checksum holds its final value in DONE until the next load_start or reset.

Test Plan:
- Reset then full load of entries mem[i]=i^8'hFF, load_valid held high -> 256 beats in 256 cycles; load_done pulses once; table_valid=1; checksum=16'h7F80; lookup 8'h40 -> lut_out=8'hBF two cycles later, lut_out_valid=1.
- Lookup with lut_in_valid=1 before any load -> lut_out_valid=0 at N+2; no X on lut_out.
- Randomly gapped load_valid (50% duty) -> same final table and checksum as the gapless load; no duplicate or skipped addresses.
- Abort at beat 100 via load_start, then a full reload with mem[i]=i -> table_valid low from the cycle after load_start until the new load_done; checksum=16'h7F80; lookup 8'h05 -> 8'h05.
- Back-to-back lookups 0x00..0xFF every cycle after load -> 256 consecutive lut_out_valid cycles, each result matching the table at latency 2.
- Assert reset during LOAD at beat 10 -> all outputs zero immediately (asynchronous); after release, state IDLE and load_ready=0 until load_start.
